trap_squash_ctrl: RTL and testbench

//  Commit-side sequencer for redirects. Keeps the oldest pending squash reason (exception or branch mispredict).

---
 rtl/trap_squash_pkg.sv | 33 +++
 rtl/trap_squash_ctrl_squash_rec_sel.sv | 38 +++
 rtl/trap_squash_ctrl.sv | 163 ++++++++++++++++
 tb/tb_trap_squash_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_squash_pkg.sv
// Shared types, widths and the ROB age comparison for the commit-side redirect sequencer.
package trap_squash_pkg;

  localparam int XLEN      = 64;
  localparam int ROB_SIZE  = 64;
  localparam int FTQ_SIZE  = 32;
  localparam int OFFSET_W  = 5;
  localparam int CAUSE_W   = 6;
  localparam int ROB_IDX_W = $clog2(ROB_SIZE);
  localparam int ROB_W     = ROB_IDX_W + 1;
  localparam int FTQ_W     = $clog2(FTQ_SIZE);

  typedef logic [ROB_W-1:0] robIdx_t;
  typedef logic [FTQ_W-1:0] ftqIdx_t;

  typedef enum logic [2:0] {IDLE, FTQ_RD, FTQ_WAIT, TRAP, SQUASH} state_t;

  typedef struct packed {
    logic               vld;
    logic               is_except;
    robIdx_t            rob;
    logic [CAUSE_W-1:0] cause;
    logic [XLEN-1:0]    npc;
    logic               taken;
  } squash_rec_t;

  // The flipped bit marks a lap of the ROB, so differing laps invert the index order.
  function automatic logic rob_older(input robIdx_t a, input robIdx_t b);
    if (a[ROB_W-1] == b[ROB_W-1]) return a[ROB_IDX_W-1:0] < b[ROB_IDX_W-1:0];
    else return a[ROB_IDX_W-1:0] > b[ROB_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/trap_squash_ctrl_squash_rec_sel.sv
// Combinational oldest-of-three pick between the pending record and this cycle's two writebacks.
module squash_rec_sel
  import trap_squash_pkg::*;
(
  input  squash_rec_t        rec,
  input  logic               except_vld,
  input  logic [ROB_W-1:0]   except_rob,
  input  logic [CAUSE_W-1:0] except_cause,
  input  logic               mispred_vld,
  input  logic [ROB_W-1:0]   mispred_rob,
  input  logic [XLEN-1:0]    mispred_npc,
  input  logic               mispred_taken,
  output squash_rec_t        rec_sel
);

  squash_rec_t cand;

  always_comb begin
    cand = '0;
    // On an age tie the exception is taken: it belongs to the same instruction and must trap.
    if (except_vld && (!mispred_vld || !rob_older(mispred_rob, except_rob))) begin
      cand.vld       = 1'b1;
      cand.is_except = 1'b1;
      cand.rob       = except_rob;
      cand.cause     = except_cause;
    end else if (mispred_vld) begin
      cand.vld   = 1'b1;
      cand.rob   = mispred_rob;
      cand.npc   = mispred_npc;
      cand.taken = mispred_taken;
    end

    rec_sel = rec;
    if (cand.vld && (!rec.vld || rob_older(cand.rob, rec.rob)))
      rec_sel = cand;
  end

endmodule

// File: rtl/trap_squash_ctrl.sv
// Commit-side redirect sequencer: tracks the oldest pending squash and drives
// either a mispredict redirect or the full FTQ-read / CSR-trap / squash sequence.
module trap_squash_ctrl
  import trap_squash_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_except_vld,
  input  logic [ROB_W-1:0]    i_except_rob,
  input  logic [CAUSE_W-1:0]  i_except_cause,
  input  logic                i_mispred_vld,
  input  logic [ROB_W-1:0]    i_mispred_rob,
  input  logic [XLEN-1:0]     i_mispred_npc,
  input  logic                i_mispred_taken,
  input  logic                i_head_vld,
  input  logic [ROB_W-1:0]    i_head_rob,
  input  logic [FTQ_W-1:0]    i_head_ftqIdx,
  input  logic [OFFSET_W-1:0] i_head_ftqOfs,
  input  logic                i_head_commit,
  output logic                o_commit_stall,
  output logic                o_ftq_rd_vld,
  output logic [FTQ_W-1:0]    o_ftq_rd_idx,
  input  logic                i_ftq_rd_rdy,
  input  logic [XLEN-1:0]     i_ftq_start_pc,
  input  logic [XLEN-1:0]     i_csr_tvec,
  output logic                o_csr_trap_vld,
  output logic [XLEN-1:0]     o_csr_epc,
  output logic [CAUSE_W-1:0]  o_csr_cause,
  output logic                o_squash_vld,
  output logic [XLEN-1:0]     o_squash_pc,
  output logic                o_squash_branch,
  output logic                o_squash_taken,
  output logic [31:0]         o_trap_cnt
);

  state_t              state_reg, state_next;
  squash_rec_t         rec_reg, rec_next, rec_sel;
  ftqIdx_t             ftq_idx_reg, ftq_idx_next;
  logic [OFFSET_W-1:0] ofs_reg, ofs_next;
  logic                trap_vld_reg, trap_vld_next;
  logic [XLEN-1:0]     epc_reg, epc_next;
  logic [CAUSE_W-1:0]  cause_reg, cause_next;
  logic                squash_vld_reg, squash_vld_next;
  logic [XLEN-1:0]     squash_pc_reg, squash_pc_next;
  logic                squash_branch_reg, squash_branch_next;
  logic                squash_taken_reg, squash_taken_next;
  logic [31:0]         trap_cnt_reg, trap_cnt_next;
  logic                mis_fire, exc_hit;

  squash_rec_sel u_rec_sel (
    .rec           (rec_reg),
    .except_vld    (i_except_vld),
    .except_rob    (i_except_rob),
    .except_cause  (i_except_cause),
    .mispred_vld   (i_mispred_vld),
    .mispred_rob   (i_mispred_rob),
    .mispred_npc   (i_mispred_npc),
    .mispred_taken (i_mispred_taken),
    .rec_sel       (rec_sel)
  );

  assign mis_fire = (state_reg == IDLE) && rec_reg.vld && !rec_reg.is_except &&
                    i_head_commit && (i_head_rob == rec_reg.rob);
  assign exc_hit  = (state_reg == IDLE) && rec_reg.vld && rec_reg.is_except &&
                    i_head_vld && (i_head_rob == rec_reg.rob);

  always_comb begin
    state_next         = state_reg;
    rec_next           = rec_reg;
    ftq_idx_next       = ftq_idx_reg;
    ofs_next           = ofs_reg;
    trap_vld_next      = 1'b0;
    epc_next           = '0;
    cause_next         = '0;
    squash_vld_next    = 1'b0;
    squash_pc_next     = '0;
    squash_branch_next = 1'b0;
    squash_taken_next  = 1'b0;
    trap_cnt_next      = trap_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (mis_fire) begin
          squash_vld_next    = 1'b1;
          squash_pc_next     = rec_reg.npc;
          squash_branch_next = 1'b1;
          squash_taken_next  = rec_reg.taken;
          rec_next           = '0;
        end else if (exc_hit) begin
          ftq_idx_next = i_head_ftqIdx;
          ofs_next     = i_head_ftqOfs;
          state_next   = FTQ_RD;
        end else begin
          rec_next = rec_sel;
        end
      end
      FTQ_RD: begin
        if (i_ftq_rd_rdy) state_next = FTQ_WAIT;
      end
      FTQ_WAIT: begin
        trap_vld_next = 1'b1;
        epc_next      = i_ftq_start_pc + XLEN'(ofs_reg);
        cause_next    = rec_reg.cause;
        state_next    = TRAP;
      end
      TRAP: begin
        squash_vld_next = 1'b1;
        squash_pc_next  = i_csr_tvec;
        state_next      = SQUASH;
      end
      SQUASH: begin
        if (trap_cnt_reg != '1) trap_cnt_next = trap_cnt_reg + 32'd1;
        rec_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      rec_reg           <= '0;
      ftq_idx_reg       <= '0;
      ofs_reg           <= '0;
      trap_vld_reg      <= 1'b0;
      epc_reg           <= '0;
      cause_reg         <= '0;
      squash_vld_reg    <= 1'b0;
      squash_pc_reg     <= '0;
      squash_branch_reg <= 1'b0;
      squash_taken_reg  <= 1'b0;
      trap_cnt_reg      <= '0;
    end else begin
      state_reg         <= state_next;
      rec_reg           <= rec_next;
      ftq_idx_reg       <= ftq_idx_next;
      ofs_reg           <= ofs_next;
      trap_vld_reg      <= trap_vld_next;
      epc_reg           <= epc_next;
      cause_reg         <= cause_next;
      squash_vld_reg    <= squash_vld_next;
      squash_pc_reg     <= squash_pc_next;
      squash_branch_reg <= squash_branch_next;
      squash_taken_reg  <= squash_taken_next;
      trap_cnt_reg      <= trap_cnt_next;
    end
  end

  // The excepting instruction is held at the head from the match cycle onwards.
  assign o_commit_stall  = (state_reg != IDLE) || exc_hit;
  assign o_ftq_rd_vld    = (state_reg == FTQ_RD);
  assign o_ftq_rd_idx    = ftq_idx_reg;
  assign o_csr_trap_vld  = trap_vld_reg;
  assign o_csr_epc       = epc_reg;
  assign o_csr_cause     = cause_reg;
  assign o_squash_vld    = squash_vld_reg;
  assign o_squash_pc     = squash_pc_reg;
  assign o_squash_branch = squash_branch_reg;
  assign o_squash_taken  = squash_taken_reg;
  assign o_trap_cnt      = trap_cnt_reg;

endmodule

// File: tb/tb_trap_squash_ctrl.sv
// Directed and randomized checks of trap_squash_ctrl against an offset-based age model.
module tb_trap_squash_ctrl;

  localparam int XW = 64;
  localparam int RW = 7;
  localparam int FW = 5;
  localparam int OW = 5;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_except_vld;
  logic [RW-1:0] i_except_rob;
  logic [CW-1:0] i_except_cause;
  logic          i_mispred_vld;
  logic [RW-1:0] i_mispred_rob;
  logic [XW-1:0] i_mispred_npc;
  logic          i_mispred_taken;
  logic          i_head_vld;
  logic [RW-1:0] i_head_rob;
  logic [FW-1:0] i_head_ftqIdx;
  logic [OW-1:0] i_head_ftqOfs;
  logic          i_head_commit;
  logic          o_commit_stall;
  logic          o_ftq_rd_vld;
  logic [FW-1:0] o_ftq_rd_idx;
  logic          i_ftq_rd_rdy;
  logic [XW-1:0] i_ftq_start_pc;
  logic [XW-1:0] i_csr_tvec;
  logic          o_csr_trap_vld;
  logic [XW-1:0] o_csr_epc;
  logic [CW-1:0] o_csr_cause;
  logic          o_squash_vld;
  logic [XW-1:0] o_squash_pc;
  logic          o_squash_branch;
  logic          o_squash_taken;
  logic [31:0]   o_trap_cnt;

  trap_squash_ctrl dut (
    .clk(clk), .rst(rst),
    .i_except_vld(i_except_vld), .i_except_rob(i_except_rob), .i_except_cause(i_except_cause),
    .i_mispred_vld(i_mispred_vld), .i_mispred_rob(i_mispred_rob), .i_mispred_npc(i_mispred_npc),
    .i_mispred_taken(i_mispred_taken),
    .i_head_vld(i_head_vld), .i_head_rob(i_head_rob), .i_head_ftqIdx(i_head_ftqIdx),
    .i_head_ftqOfs(i_head_ftqOfs), .i_head_commit(i_head_commit),
    .o_commit_stall(o_commit_stall), .o_ftq_rd_vld(o_ftq_rd_vld), .o_ftq_rd_idx(o_ftq_rd_idx),
    .i_ftq_rd_rdy(i_ftq_rd_rdy), .i_ftq_start_pc(i_ftq_start_pc), .i_csr_tvec(i_csr_tvec),
    .o_csr_trap_vld(o_csr_trap_vld), .o_csr_epc(o_csr_epc), .o_csr_cause(o_csr_cause),
    .o_squash_vld(o_squash_vld), .o_squash_pc(o_squash_pc), .o_squash_branch(o_squash_branch),
    .o_squash_taken(o_squash_taken), .o_trap_cnt(o_trap_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    i_except_vld = 0; i_except_rob = '0; i_except_cause = '0;
    i_mispred_vld = 0; i_mispred_rob = '0; i_mispred_npc = '0; i_mispred_taken = 0;
  endtask

  task automatic clear_all();
    clear_wb();
    i_head_vld = 0; i_head_rob = '0; i_head_ftqIdx = '0; i_head_ftqOfs = '0; i_head_commit = 0;
    i_ftq_rd_rdy = 0; i_ftq_start_pc = '0; i_csr_tvec = '0;
  endtask

  // One writeback cycle while idle: nothing may redirect yet.
  task automatic wb(input logic ev, input logic [RW-1:0] er, input logic [CW-1:0] ec,
                    input logic mv, input logic [RW-1:0] mr, input logic [XW-1:0] np,
                    input logic tk);
    i_except_vld = ev; i_except_rob = er; i_except_cause = ec;
    i_mispred_vld = mv; i_mispred_rob = mr; i_mispred_npc = np; i_mispred_taken = tk;
    #1;
    check("wb_stall", o_commit_stall, 0);
    check("wb_squash", o_squash_vld, 0);
    adv();
    clear_wb();
    $display("wb     exc=%0b rob=%0d cause=%0d mis=%0b rob=%0d npc=0x%0h", ev, er, ec, mv, mr, np);
  endtask

  task automatic run_mispred(input logic [RW-1:0] rob, input logic [XW-1:0] np, input logic tk);
    i_head_vld = 1; i_head_commit = 1; i_head_rob = rob;
    #1;
    check("mp_head_stall", o_commit_stall, 0);
    adv();
    i_head_vld = 0; i_head_commit = 0;
    #1;
    check("mp_squash_vld", o_squash_vld, 1);
    check("mp_squash_pc", o_squash_pc, np);
    check("mp_branch", o_squash_branch, 1);
    check("mp_taken", o_squash_taken, tk);
    check("mp_stall", o_commit_stall, 0);
    check("mp_trap", o_csr_trap_vld, 0);
    adv();
    #1;
    check("mp_squash_end", o_squash_vld, 0);
    $display("mispred rob=%0d npc=0x%0h taken=%0b", rob, np, tk);
  endtask

  task automatic run_except(input logic [RW-1:0] rob, input logic [CW-1:0] cause,
                            input logic [FW-1:0] fidx, input logic [OW-1:0] ofs, input int dly,
                            input logic [XW-1:0] spc, input logic [XW-1:0] tv,
                            input bit junk, input bit abort);
    logic [XW-1:0] epc;
    epc = spc + XW'(ofs);
    i_head_vld = 1; i_head_commit = 0; i_head_rob = rob; i_head_ftqIdx = fidx; i_head_ftqOfs = ofs;
    #1;
    check("ex_match_stall", o_commit_stall, 1);
    check("ex_match_rd", o_ftq_rd_vld, 0);
    adv();
    i_head_vld = 0; i_head_ftqIdx = ~fidx; i_head_ftqOfs = ~ofs;
    for (int k = 0; k < dly; k++) begin
      if (junk && k == 0) begin
        i_except_vld = 1; i_except_rob = RW'(rob - 7'd1); i_except_cause = ~cause;
        i_mispred_vld = 1; i_mispred_rob = RW'(rob - 7'd2); i_mispred_npc = ~tv;
      end
      #1;
      check("ex_rd_vld", o_ftq_rd_vld, 1);
      check("ex_rd_idx", o_ftq_rd_idx, fidx);
      check("ex_rd_stall", o_commit_stall, 1);
      check("ex_rd_trap", o_csr_trap_vld, 0);
      adv();
      clear_wb();
    end
    i_ftq_rd_rdy = 1;
    #1;
    check("ex_rdy_vld", o_ftq_rd_vld, 1);
    check("ex_rdy_idx", o_ftq_rd_idx, fidx);
    adv();
    i_ftq_rd_rdy = 0; i_ftq_start_pc = spc;
    #1;
    check("ex_wait_stall", o_commit_stall, 1);
    check("ex_wait_rd", o_ftq_rd_vld, 0);
    check("ex_wait_trap", o_csr_trap_vld, 0);
    adv();
    i_ftq_start_pc = ~spc; i_csr_tvec = tv;
    #1;
    check("ex_trap_vld", o_csr_trap_vld, 1);
    check("ex_epc", o_csr_epc, epc);
    check("ex_cause", o_csr_cause, cause);
    check("ex_trap_stall", o_commit_stall, 1);
    check("ex_trap_squash", o_squash_vld, 0);
    if (abort) begin
      rst = 1;
      adv();
      rst = 0; exp_cnt = 0;
      #1;
      check("rst_stall", o_commit_stall, 0);
      check("rst_rd_vld", o_ftq_rd_vld, 0);
      check("rst_rd_idx", o_ftq_rd_idx, 0);
      check("rst_trap", o_csr_trap_vld, 0);
      check("rst_epc", o_csr_epc, 0);
      check("rst_cause", o_csr_cause, 0);
      check("rst_squash", o_squash_vld, 0);
      check("rst_squash_pc", o_squash_pc, 0);
      check("rst_cnt", o_trap_cnt, 0);
      adv();
      #1;
      check("rst_no_squash", o_squash_vld, 0);
      check("rst_no_trap", o_csr_trap_vld, 0);
      $display("abort  rob=%0d reset in trap", rob);
      return;
    end
    adv();
    i_csr_tvec = ~tv;
    if (exp_cnt < 32'hFFFF_FFFF) exp_cnt++;
    #1;
    check("ex_squash_vld", o_squash_vld, 1);
    check("ex_squash_pc", o_squash_pc, tv);
    check("ex_squash_branch", o_squash_branch, 0);
    check("ex_squash_stall", o_commit_stall, 1);
    check("ex_squash_trap", o_csr_trap_vld, 0);
    adv();
    #1;
    check("ex_idle_squash", o_squash_vld, 0);
    check("ex_idle_stall", o_commit_stall, 0);
    check("ex_trap_cnt", o_trap_cnt, 32'(exp_cnt));
    $display("except rob=%0d cause=%0d epc=0x%0h tvec=0x%0h dly=%0d", rob, cause, epc, tv, dly);
  endtask

  // Age model: work in offsets from a base ROB position; smaller offset means older.
  task automatic random_episode();
    int base, n, eo, mo, win_off, cand_off;
    bit have, ev, mv, cand_exc, cand_ok, win_exc;
    logic [CW-1:0] ec, win_cause;
    logic [XW-1:0] np, win_npc;
    logic tk, win_tk;
    base = $urandom_range(0, 127);
    n = $urandom_range(1, 4);
    have = 0; win_off = 0; win_exc = 0; win_cause = '0; win_npc = '0; win_tk = 0;
    for (int c = 0; c < n; c++) begin
      ev = 1'($urandom % 2); mv = 1'($urandom % 2);
      if (c == n - 1 && !have && !ev && !mv) ev = 1;
      eo = $urandom_range(0, 19); mo = $urandom_range(0, 19);
      ec = CW'($urandom); np = {$urandom, $urandom}; tk = 1'($urandom % 2);
      cand_ok = ev || mv;
      cand_exc = ev && (!mv || eo <= mo);
      cand_off = cand_exc ? eo : mo;
      if (cand_ok && (!have || cand_off < win_off)) begin
        have = 1; win_off = cand_off; win_exc = cand_exc;
        win_cause = ec; win_npc = np; win_tk = tk;
      end
      wb(ev, RW'(base + eo), ec, mv, RW'(base + mo), np, tk);
    end
    if (win_exc)
      run_except(RW'(base + win_off), win_cause, FW'($urandom), OW'($urandom), $urandom_range(0, 3),
                 {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom % 2), 0);
    else
      run_mispred(RW'(base + win_off), win_npc, win_tk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    clear_all();
    repeat (3) adv();
    #1;
    check("reset_stall", o_commit_stall, 0);
    check("reset_rd_vld", o_ftq_rd_vld, 0);
    check("reset_trap", o_csr_trap_vld, 0);
    check("reset_squash", o_squash_vld, 0);
    check("reset_cnt", o_trap_cnt, 0);
    rst = 0;
    adv();

    // Mispredict at {0,5}
    wb(0, '0, '0, 1, 7'd5, 64'h8000_0100, 1);
    run_mispred(7'd5, 64'h8000_0100, 1);
    // Exception at {0,3}, ready immediately
    wb(1, 7'd3, 6'd2, 0, '0, '0, 0);
    run_except(7'd3, 6'd2, 5'd9, 5'd6, 0, 64'h1000, 64'h2000, 0, 0);
    // Older mispredict beats a same-cycle exception
    wb(1, 7'd7, 6'd1, 1, 7'd4, 64'h4444, 0);
    run_mispred(7'd4, 64'h4444, 0);
    // Equal age: exception wins
    wb(1, 7'd4, 6'd5, 1, 7'd4, 64'h5555, 1);
    run_except(7'd4, 6'd5, 5'd1, 5'd0, 1, 64'h3000, 64'h3100, 0, 0);
    // Record {1,2} replaced by {0,62}, older across the wrap
    wb(0, '0, '0, 1, 7'h42, 64'h6666, 1);
    wb(1, 7'd62, 6'd7, 0, '0, '0, 0);
    run_except(7'd62, 6'd7, 5'd31, 5'd3, 0, 64'h7000, 64'h7100, 0, 0);
    // Ready held off five cycles; epc wraps mod 2^64
    wb(1, 7'd10, 6'd3, 0, '0, '0, 0);
    run_except(7'd10, 6'd3, 5'd17, 5'd31, 5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8000, 1, 0);
    // Reset while in TRAP
    wb(1, 7'd20, 6'd4, 0, '0, '0, 0);
    run_except(7'd20, 6'd4, 5'd2, 5'd2, 0, 64'h9000, 64'h9100, 0, 1);

    for (int ep = 0; ep < 150; ep++) random_episode();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
